selftrigger_channel_arbiter: RTL
================================

SELFTRIGGER_CHANNEL_ARBITER -- requirements
Module: selftrigger_channel_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 8: number of self-trigger channels, 2..16.
REQ-002 SHALL have parameter HOLDOFF, default 1024: per-channel dead time in clk cycles after an accepted trigger, 1..65535.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1: high = accept new triggers.
REQ-006 SHALL have port trig_in, input, NCH: per-channel trigger_output from the filter/trigger chains.
REQ-007 SHALL have port timestamp, input, 64: free-running timestamp.
REQ-008 SHALL have port rd_req, output, 1: readout request to the shared record builder.
REQ-009 SHALL have port rd_channel, output, 4: granted channel index.
REQ-010 SHALL have port rd_timestamp, output, 64: timestamp captured at trigger acceptance for rd_channel.
REQ-011 SHALL have port rd_ack, input, 1: builder accepted the request.
REQ-012 SHALL have port rd_done, input, 1: builder finished the record.
REQ-013 SHALL have port pending, output, NCH: per-channel pending flags.
REQ-014 SHALL have port drop_count, output, 16: saturating count of lost triggers.

Function
REQ-015 SHALL detect a trigger on channel i when trig_in[i] is 1 and was 0 in the previous cycle; a held level counts once.
REQ-016 SHALL accept a detected trigger when enable=1, pending[i]=0 and channel i is not in holdoff: set pending[i] and capture timestamp into ts[i] on the next edge.
REQ-017 SHALL increment drop_count by 1, saturating at 65535, for a trigger detected while enable=1 and pending[i]=1; holdoff or enable=0 rejections are not counted; multiple drops in one cycle count as 1.
REQ-018 SHALL implement FSM IDLE -> REQ -> BUSY -> IDLE.
REQ-019 In IDLE, if any pending bit is set, the FSM SHALL pick the first set channel searching round-robin from last_grant+1 (wrapping at NCH-1 to 0), register rd_channel and rd_timestamp=ts[sel], assert rd_req and enter REQ.
REQ-020 In REQ, rd_req SHALL stay high with stable rd_channel and rd_timestamp until rd_ack=1 is sampled; then deassert rd_req and enter BUSY.
REQ-021 In BUSY, on rd_done=1 the FSM SHALL clear pending[rd_channel], set last_grant=rd_channel and return to IDLE; rd_done outside BUSY and rd_ack outside REQ SHALL be ignored.
REQ-022 A new trigger on rd_channel in the cycle its pending bit clears SHALL be accepted (set wins) if not in holdoff.
REQ-023 Latency: trigger edge sampled at cycle t with FSM idle -> pending at t+1 -> rd_req high at t+2.
REQ-024 enable=0 SHALL NOT abort the FSM; already-pending channels SHALL still be served.
REQ-025 last_grant SHALL reset to NCH-1, so channel 0 has first priority after reset.

Reset
REQ-026 On reset=1 at a clk edge: FSM=IDLE, rd_req=0, rd_channel=0, rd_timestamp=0, pending=0, drop_count=0, all holdoff counters=0, edge-detect history=0, ts[]=0.
REQ-027 Reset mid-transaction SHALL drop the in-flight grant without waiting for rd_ack or rd_done.

Configuration
REQ-028 With macro SELFTRIG_HOLDOFF_EN defined, each accepted trigger SHALL load a per-channel counter with HOLDOFF; the channel is in holdoff while the counter is nonzero, and the counter decrements by 1 per cycle.
REQ-029 Without SELFTRIG_HOLDOFF_EN, no holdoff counters SHALL exist; acceptance depends only on enable and pending; HOLDOFF is unused.

Verification
REQ-030 Single trigger: after reset, ch2 edge with timestamp=100 -> rd_req two cycles later, rd_channel=2, rd_timestamp=100; ack then done -> pending=0.
REQ-031 Round-robin: ch1, ch3 and ch5 edges in the same cycle, last_grant=3 -> grants in order 5, 1, 3.
REQ-032 Drop count: ch0 pending and not yet granted, 3 more edges on ch0 with holdoff disabled -> drop_count=3; drive drop_count to 65535, then 1 more drop -> stays 65535.
REQ-033 Holdoff (SELFTRIG_HOLDOFF_EN, HOLDOFF=10): ch4 edge at t, served by t+6, second edge at t+8 -> ignored, drop_count unchanged; edge at t+12 -> accepted.
REQ-034 Handshake: rd_ack held 0 for 20 cycles -> rd_req, rd_channel and rd_timestamp stable throughout; rd_done pulsed in REQ -> ignored.
REQ-035 Reset while BUSY with 2 channels pending -> next cycle rd_req=0, pending=0, FSM=IDLE; a later rd_done has no effect.

Source files
------------

// File: rtl/selftrigger_channel_arbiter.sv
// selftrigger_channel_arbiter: round-robin arbiter granting pending self-trigger channels to a shared record builder
// Ports: clk, reset (sync, active-high), enable (accept new triggers), trig_in[NCH] (trigger levels),
//        timestamp[64] (free-running), rd_req/rd_channel/rd_timestamp (request to builder),
//        rd_ack/rd_done (builder handshake), pending[NCH] (per-channel flags), drop_count[16] (saturating losses).
// Macro SELFTRIG_HOLDOFF_EN: adds a per-channel dead time of HOLDOFF cycles after each accepted trigger.
module selftrigger_channel_arbiter #(
  parameter int NCH = 8,
  parameter int HOLDOFF = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [NCH-1:0]  trig_in,
  input  logic [63:0]     timestamp,
  output logic            rd_req,
  output logic [3:0]      rd_channel,
  output logic [63:0]     rd_timestamp,
  input  logic            rd_ack,
  input  logic            rd_done,
  output logic [NCH-1:0]  pending,
  output logic [15:0]     drop_count
);
  typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;
  state_t state, state_nx;
  logic [NCH-1:0] trig_q, rise, hold, clr, pend_eff, accept;
  logic [63:0] ts [NCH];
  logic [63:0] sel_ts;
  logic [3:0] last_grant, sel;
  logic drop;
  assign rise = trig_in & ~trig_q;
  assign clr = (state == BUSY && rd_done) ? NCH'(1) << rd_channel : '0;
  // a bit being cleared this cycle counts as free, so a coincident new trigger re-arms it
  assign pend_eff = pending & ~clr;
  assign accept = enable ? rise & ~pend_eff & ~hold : '0;
  assign drop = enable && |(rise & pend_eff);
  assign rd_req = (state == REQ);
`ifdef SELFTRIG_HOLDOFF_EN
  logic [15:0] hcnt [NCH];
  always_ff @(posedge clk)
    for (int i = 0; i < NCH; i++)
      hcnt[i] <= reset ? '0 : accept[i] ? 16'(HOLDOFF) : (hcnt[i] != '0) ? hcnt[i] - 16'd1 : hcnt[i];
  for (genvar g = 0; g < NCH; g++) assign hold[g] = (hcnt[g] != '0);
`else
  assign hold = '0;
`endif
  // nearest pending channel after last_grant wins: farther candidates are overwritten by nearer ones
  always_comb begin
    sel = '0;
    for (int k = NCH; k >= 1; k--)
      for (int i = 0; i < NCH; i++)
        if (pending[i] && (int'(last_grant) + k == i || int'(last_grant) + k == i + NCH)) sel = 4'(i);
  end
  always_comb begin
    sel_ts = '0;
    for (int i = 0; i < NCH; i++)
      if (sel == 4'(i)) sel_ts = ts[i];
  end
  always_comb begin
    state_nx = (state == IDLE && |pending) ? REQ :
               (state == REQ && rd_ack) ? BUSY :
               (state == BUSY && rd_done) ? IDLE : state;
  end
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (reset) begin
      trig_q <= '0;
      pending <= '0;
      drop_count <= '0;
      rd_channel <= '0;
      rd_timestamp <= '0;
      last_grant <= 4'(NCH - 1);
      for (int i = 0; i < NCH; i++) ts[i] <= '0;
    end else begin
      trig_q <= trig_in;
      pending <= pend_eff | accept;
      for (int i = 0; i < NCH; i++)
        if (accept[i]) ts[i] <= timestamp;
      if (drop && drop_count != 16'hffff) drop_count <= drop_count + 16'd1;
      if (state == IDLE && |pending) begin
        rd_channel <= sel;
        rd_timestamp <= sel_ts;
      end
      if (|clr) last_grant <= rd_channel;
    end
  end
endmodule
